// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: per-stage butterfly pair address sequencer with latency-matched in-place write-back
module ntt_stage_ctrl #(
  parameter int N = 512,
  parameter int LOGN = 9,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sel_ntt,
  input  logic [3:0]      stage,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            pe_sel_ntt,
  output logic            rd_en,
  output logic [LOGN-1:0] ra_u,
  output logic [LOGN-1:0] ra_v,
  output logic            we,
  output logic [LOGN-1:0] wa_u,
  output logic [LOGN-1:0] wa_v
);
  localparam int D = RD_LAT + PE_LAT;
  localparam logic [LOGN-2:0] LAST = (LOGN-1)'(N/2 - 1);
  localparam logic [LOGN-2:0] DLAST = (LOGN-1)'(D - 1);
  localparam logic [3:0] SMAX = 4'(LOGN - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t st;
  logic [LOGN-2:0] i, pi;
  logic [3:0] bl, bs, pb;
  logic [LOGN-1:0] span, mask, ext, nu;
  logic [D-1:0] pv;
  logic [LOGN-1:0] pu [D];
  logic [LOGN-1:0] pw [D];
  // address of the next pair: insert a zero at bit b of the pair index
  always_comb begin
    bs = sel_ntt ? stage : SMAX - stage;
    pi = (st == ISSUE) ? i + 1'b1 : '0;
    pb = (st == ISSUE) ? bl : bs;
    span = LOGN'(1) << pb;
    mask = span - 1'b1;
    ext = {1'b0, pi};
    nu = ((ext & ~mask) << 1) | (ext & mask);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      i <= '0;
      bl <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      pe_sel_ntt <= 1'b0;
      rd_en <= 1'b0;
      ra_u <= '0;
      ra_v <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (st)
        ISSUE: begin
          if (i == LAST) begin
            st <= DRAIN;
            rd_en <= 1'b0;
            i <= '0;
          end else begin
            i <= pi;
            ra_u <= nu;
            ra_v <= nu | span;
          end
        end
        DRAIN: begin
          if (i == DLAST) begin
            st <= FIN;
            done <= 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end
        default: begin
          // FIN also accepts a start so consecutive stages run without a gap
          st <= IDLE;
          busy <= 1'b0;
          if (start && stage > SMAX) begin
            err <= 1'b1;
          end else if (start) begin
            st <= ISSUE;
            busy <= 1'b1;
            rd_en <= 1'b1;
            i <= '0;
            bl <= bs;
            pe_sel_ntt <= sel_ntt;
            ra_u <= nu;
            ra_v <= nu | span;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < D; k++) begin
        pu[k] <= '0;
        pw[k] <= '0;
      end
    end else begin
      pv <= {pv[D-2:0], rd_en};
      pu[0] <= ra_u;
      pw[0] <= ra_v;
      for (int k = 1; k < D; k++) begin
        pu[k] <= pu[k-1];
        pw[k] <= pw[k-1];
      end
    end
  end
  assign we = pv[D-1];
  assign wa_u = pu[D-1];
  assign wa_v = pw[D-1];
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: cycle-exact stage timing plus RAM/butterfly round-trip model for ntt_stage_ctrl
module tb_ntt_stage_ctrl;
  localparam longint Q = 12289;
  localparam longint INV2 = 6145;
  typedef struct {longint a; longint b;} pr_t;
  logic clk = 1'b0;
  logic rst, start, sel_ntt;
  logic [3:0] stage;
  logic busy, done, err, pe_sel_ntt, rd_en, we;
  logic [8:0] ra_u, ra_v, wa_u, wa_v;
  int pass_cnt = 0;
  int tot = 0;
  longint mem [512];
  longint orig [512];
  int wcnt [512];
  int cap_u [256];
  int cap_v [256];
  pr_t fifo [$];

  ntt_stage_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sel_ntt(sel_ntt), .stage(stage),
    .busy(busy), .done(done), .err(err), .pe_sel_ntt(pe_sel_ntt), .rd_en(rd_en),
    .ra_u(ra_u), .ra_v(ra_v), .we(we), .wa_u(wa_u), .wa_v(wa_v)
  );

  always #5 clk = ~clk;

  function automatic int pa(input int k, input int l);
    return (k / l) * 2 * l + k % l;
  endfunction

  function automatic longint mpow(input longint x, input longint e);
    longint r;
    r = 1;
    while (e > 0) begin
      if (e[0]) r = r * x % Q;
      x = x * x % Q;
      e = e >> 1;
    end
    return r;
  endfunction

  // any nonzero twiddle keyed on (half-span, u address) makes each inverse stage undo its forward twin
  function automatic longint tw(input int b, input int u);
    return longint'((u * 7 + b * 31) % (Q - 1) + 1);
  endfunction

  task automatic run_stage(input bit s, input int stg, input int poke);
    int b, l, bad;
    logic [41:0] act, want;
    logic [8:0] eu, ev, xu, xv;
    longint u, v, w, t;
    pr_t p;
    b = s ? stg : 8 - stg;
    l = 1 << b;
    foreach (wcnt[n]) wcnt[n] = 0;
    foreach (cap_u[n]) begin
      cap_u[n] = -1;
      cap_v[n] = -1;
    end
    sel_ntt = s;
    stage = 4'(stg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 264; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (c == poke) begin
        start = 1'b1;
        sel_ntt = ~s;
        stage = 4'($urandom_range(0, 8));
      end
      eu = (c <= 256) ? 9'(pa(c - 1, l)) : 9'd0;
      ev = (c <= 256) ? eu + 9'(l) : 9'd0;
      xu = (c >= 8 && c <= 263) ? 9'(pa(c - 8, l)) : 9'd0;
      xv = (c >= 8 && c <= 263) ? xu + 9'(l) : 9'd0;
      want = {1'b1, 1'(c == 264), 1'b0, 1'(c <= 256), 1'(c >= 8 && c <= 263), s, eu, ev, xu, xv};
      act = {busy, done, err, rd_en, we, pe_sel_ntt, rd_en ? ra_u : 9'd0, rd_en ? ra_v : 9'd0,
             we ? wa_u : 9'd0, we ? wa_v : 9'd0};
      tot++;
      if (act !== want)
        $display("FAIL stage_timing sel=%0d stage=%0d cycle=T+%0d got %h expected %h", s, stg, c, act, want);
      else
        pass_cnt++;
      if (rd_en === 1'b1) begin
        if (c <= 256) begin
          cap_u[c-1] = int'(ra_u);
          cap_v[c-1] = int'(ra_v);
        end
        u = mem[ra_u];
        v = mem[ra_v];
        w = tw(b, int'(ra_u));
        if (!s) begin
          t = w * v % Q;
          p.a = (u + t) % Q;
          p.b = (u - t + Q) % Q;
        end else begin
          p.a = (u + v) * INV2 % Q;
          p.b = (u - v + Q) % Q * INV2 % Q * mpow(w, Q - 2) % Q;
        end
        fifo.push_back(p);
      end
      if (we === 1'b1) begin
        tot++;
        if (fifo.size() == 0) begin
          $display("FAIL writeback_pending cycle=T+%0d got write with 0 outstanding reads expected >=1", c);
        end else begin
          pass_cnt++;
          p = fifo.pop_front();
          mem[wa_u] = p.a;
          mem[wa_v] = p.b;
          wcnt[wa_u]++;
          wcnt[wa_v]++;
        end
      end
    end
    bad = 0;
    foreach (wcnt[n]) if (wcnt[n] != 1) bad++;
    tot++;
    if (bad != 0) $display("FAIL written_once sel=%0d stage=%0d got %0d bad addresses expected 0", s, stg, bad);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    sel_ntt = 1'b0;
    stage = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    tot++;
    if ({busy, done, err, rd_en, we, pe_sel_ntt, ra_u, ra_v, wa_u, wa_v} !== 42'd0)
      $display("FAIL reset_values got %h expected 0",
               {busy, done, err, rd_en, we, pe_sel_ntt, ra_u, ra_v, wa_u, wa_v});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_ntt_stage0;
    run_stage(1'b0, 0, 0);
    tot++;
    if ({cap_u[0], cap_v[0]} !== {32'd0, 32'd256})
      $display("FAIL ntt0_pair0 got %0d/%0d expected 0/256", cap_u[0], cap_v[0]);
    else pass_cnt++;
    tot++;
    if ({cap_u[255], cap_v[255]} !== {32'd255, 32'd511})
      $display("FAIL ntt0_pair255 got %0d/%0d expected 255/511", cap_u[255], cap_v[255]);
    else pass_cnt++;
  endtask

  task automatic test_intt_stage0;
    run_stage(1'b1, 0, 50);
    tot++;
    if ({cap_u[0], cap_v[0], cap_u[1], cap_v[1]} !== {32'd0, 32'd1, 32'd2, 32'd3})
      $display("FAIL intt0_pairs01 got %0d/%0d %0d/%0d expected 0/1 2/3", cap_u[0], cap_v[0], cap_u[1], cap_v[1]);
    else pass_cnt++;
    tot++;
    if ({cap_u[255], cap_v[255]} !== {32'd510, 32'd511})
      $display("FAIL intt0_pair255 got %0d/%0d expected 510/511", cap_u[255], cap_v[255]);
    else pass_cnt++;
    tot++;
    if (pe_sel_ntt !== 1'b1) $display("FAIL intt0_pe_sel got %b expected 1", pe_sel_ntt);
    else pass_cnt++;
  endtask

  task automatic test_span8;
    run_stage(1'b1, 3, 263);
    tot++;
    if ({cap_u[9], cap_v[9]} !== {32'd17, 32'd25})
      $display("FAIL intt3_pair9 got %0d/%0d expected 17/25", cap_u[9], cap_v[9]);
    else pass_cnt++;
    run_stage(1'b0, 5, 120);
    tot++;
    if ({cap_u[9], cap_v[9]} !== {32'd17, 32'd25})
      $display("FAIL ntt5_pair9 got %0d/%0d expected 17/25", cap_u[9], cap_v[9]);
    else pass_cnt++;
  endtask

  task automatic test_err;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      start = 1'b1;
      stage = n ? 4'd15 : 4'd9;
      sel_ntt = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      tot++;
      if ({err, busy, rd_en} !== 3'b100) $display("FAIL err_pulse stage=%0d got %b expected 100", stage, {err, busy, rd_en});
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        tot++;
        if ({err, busy, rd_en, we, done} !== 5'd0)
          $display("FAIL err_after stage=%0d got %b expected 00000", stage, {err, busy, rd_en, we, done});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(posedge clk); #1;
    start = 1'b1;
    sel_ntt = 1'b0;
    stage = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    tot++;
    if ({busy, rd_en, we} !== 3'b111) $display("FAIL mid_active got %b expected 111", {busy, rd_en, we});
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tot++;
    if ({busy, rd_en, we, done} !== 4'd0) $display("FAIL mid_reset got %b expected 0000", {busy, rd_en, we, done});
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if ({busy, rd_en, we, done} !== 4'd0) seen++;
    end
    tot++;
    if (seen != 0) $display("FAIL abandoned_stage got %0d active cycles expected 0", seen);
    else pass_cnt++;
    run_stage(1'b0, 2, 0);
  endtask

  task automatic test_back_to_back;
    int diff;
    @(posedge clk); #1;
    fifo.delete();
    foreach (mem[n]) begin
      mem[n] = longint'($urandom_range(0, 12288));
      orig[n] = mem[n];
    end
    for (int s = 0; s <= 8; s++) run_stage(1'b0, s, 0);
    for (int s = 0; s <= 8; s++) run_stage(1'b1, s, 0);
    @(posedge clk); #1;
    tot++;
    if ({busy, done, we, rd_en} !== 4'd0) $display("FAIL chain_idle got %b expected 0000", {busy, done, we, rd_en});
    else pass_cnt++;
    diff = 0;
    foreach (mem[n]) if (mem[n] != orig[n]) diff++;
    tot++;
    if (diff != 0) $display("FAIL round_trip got %0d differing coefficients expected 0", diff);
    else pass_cnt++;
  endtask

  initial begin
    foreach (mem[n]) mem[n] = longint'($urandom_range(0, 12288));
    test_reset;
    test_ntt_stage0;
    test_intt_stage0;
    test_span8;
    test_err;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule

// File: doc/ntt_stage_ctrl.md
# ntt_stage_ctrl

Stage sequencer and write-back controller for the 512-point NTT/INTT datapath. For one butterfly stage it generates the coefficient-pair read addresses (u, v) for the dual-port coefficient RAM and drives the mode select of the butterfly processing element. It delays the same address pair through a latency-matched pipeline so the butterfly results land back in place. It sits between the top-level NTT controller, which issues one `start` per stage, and the RAM/butterfly pair.

## Interface

- `N`, 512: transform length.
- `LOGN`, 9: log2(N); address width.
- `RD_LAT`, 1: RAM read latency in cycles.
- `PE_LAT`, 6: butterfly latency, u/v input to `bf_upper`/`bf_lower` output (identical in both modes).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: one-cycle request to run a stage; ignored while `busy`.
- `sel_ntt` input 1: 0 = forward NTT (CT), 1 = inverse (GS); sampled with `start`.
- `stage` input 4: stage index 0..8; sampled with `start`.
- `busy` output 1: stage in progress.
- `done` output 1: one-cycle pulse after the last write.
- `err` output 1: one-cycle pulse when `start` arrives with `stage` > 8.
- `pe_sel_ntt` output 1: latched mode, driven to the butterfly.
- `rd_en` output 1: RAM read strobe.
- `ra_u`, `ra_v` output LOGN: read addresses of the pair.
- `we` output 1: RAM write strobe.
- `wa_u` output LOGN: write address for `bf_lower`.
- `wa_v` output LOGN: write address for `bf_upper`.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: on `start` with `stage` ≤ 8:
  - latch `sel_ntt` and `stage`;
  - clear pair counter `i` (8 bits, 0..N/2-1);
  - go to ISSUE.
- IDLE: on `start` with `stage` > 8, pulse `err` next cycle and stay in IDLE.
- ISSUE: `rd_en`=1 every cycle, issuing pair `i`. After `i`=255, go to DRAIN.
- DRAIN: `rd_en`=0; wait for the pipeline to empty (RD_LAT+PE_LAT cycles), then go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- Half-span `L` = 2^b, with b = 8−stage (NTT) or b = stage (INTT).
- Address rule:
  - `ra_u` = ((i >> b) << (b+1)) | (i & (L−1)), i.e. insert a 0 bit at position b of `i`;
  - `ra_v` = `ra_u` | L.
- Write-back pipeline: shift register of depth RD_LAT+PE_LAT carrying {valid, ra_u, ra_v}.
  - The output tap drives `we`, `wa_u`, `wa_v`.
  - Valid is shifted in from `rd_en`.
- `bf_lower` always returns to u and `bf_upper` to v, in both modes. Addresses are mode-independent apart from `b`.
- `start` during `busy` is ignored and has no effect on latched parameters.
- `rst` at any time: FSM to IDLE, counter cleared, all pipeline valids cleared, so `we`=0 from the next cycle. A partial stage is abandoned; no `done`.

## Timing

- Reset values: `busy`, `done`, `err`, `rd_en`, `we` = 0; `ra_u`, `ra_v`, `wa_u`, `wa_v` = 0; `pe_sel_ntt` = 0.
- All outputs are registered.
- With `start` sampled at edge T:
  - `busy`=1 on cycles T+1..T+264;
  - `rd_en`=1 on T+1..T+256 (pair `i` on cycle T+1+i);
  - RAM data reaches the butterfly on T+2+i;
  - `we`=1 with pair `i` addresses on T+8+i (T+8..T+263);
  - `done` on T+264;
  - a new `start` is accepted at T+264 or later.
- Total stage time: N/2 + RD_LAT + PE_LAT + 1 = 264 cycles.
- `pe_sel_ntt` is updated on T+1 and held until the next accepted `start`.
- Back-to-back stages never overlap. Read/write address conflict within a stage is impossible because each pair is written exactly RD_LAT+PE_LAT cycles after its read.

## Test plan

- NTT, stage 0 → b=8:
  - i=0 gives `ra_u`=0, `ra_v`=256;
  - i=255 gives 255/511;
  - `we` on T+8..T+263 with `wa_u`/`wa_v` matching the reads 7 cycles earlier;
  - `done` only at T+264.
- INTT, stage 0 → b=0: i=0 gives 0/1; i=1 gives 2/3; i=255 gives 510/511; `pe_sel_ntt`=1.
- INTT, stage 3 → b=3: i=9 gives `ra_u`=17, `ra_v`=25. NTT stage 5 gives the same b=3, so the same addresses.
- `start` with `stage`=9 → `err` pulses once, `busy` stays 0, no `rd_en`. A second `start` during `busy` → no change to timing or addresses.
- Assert `rst` at T+100 → next cycle `busy`, `rd_en`, `we` = 0 and no `done`. A fresh `start` afterwards runs a full correct 264-cycle stage.
- All 9 NTT stages then all 9 INTT stages, with a butterfly model (latency 6) and RAM model (q=12289) → every address in 0..511 is written exactly once per stage, and the INTT∘NTT round trip restores the input vector.
